switch_port_dbnc: RTL
=====================

// Module: switch_port_dbnc
// PURPOSE
//  Parametrised memory-mapped switch/button input port for the MIPS SoC bus.
//  - Per bit: 2-flop synchroniser, then counter debounce.
//  - Per-bit edge detection into sticky, write-1-to-clear flags, with a maskable interrupt.
//  - CPU reads the debounced level or the edge flags. CPU programs the edge mode and IRQ enable.
// PARAMETERS
//  WIDTH            16  number of switch inputs, 1..16; read data zero-extended to 16 bits
//  DEBOUNCE_CYCLES  4   consecutive clocks a new level must persist, >=1
//  CNT_W            3   counter width, must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  switclk       in   1      bus clock; all state changes on negedge switclk
//  switrst       in   1      reset, asynchronous, active-high
//  switchaddrcs  in   1      port chip select from address decoder
//  switchread    in   1      read strobe
//  switchwrite   in   1      write strobe
//  switchaddr    in   2      register select: 0 DATA, 1 EDGE, 2 IE, 3 MODE
//  switchwdata   in   16     write data, bits [WIDTH-1:0] used
//  switchrdata   out  16     registered read data
//  switch_i      in   WIDTH  raw asynchronous switch levels
//  switchirq     out  1      registered interrupt request, active-high level
// BEHAVIOUR
//  Reset (async): cleared to 0 are sync1, sync2, stable, all counters, edge, ie, mode,
//   switchrdata and switchirq.
//  Synchroniser: sync1<=switch_i; sync2<=sync1.
//  Debounce, per bit, each negedge:
//   - If sync2==stable: cnt<=0.
//   - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0.
//   - Else: cnt<=cnt+1.
//   - A level held from sampling edge 1 becomes stable on edge DEBOUNCE_CYCLES+2.
//   - A glitch shorter than DEBOUNCE_CYCLES clocks at sync2 never reaches stable.
//     Any return to the old level restarts the count from 0.
//  Edge detect: on the edge where stable[i] changes:
//   - mode[i]=0: a 0->1 change sets edge[i].
//   - mode[i]=1: a 1->0 change sets edge[i].
//   - Flags are sticky until cleared.
//  Writes (switchaddrcs && switchwrite, negedge):
//   - addr0: ignored.
//   - addr1: edge <= edge & ~wdata (W1C). If a set and a clear hit the same bit
//     in the same cycle, the set wins.
//   - addr2: ie <= wdata.
//   - addr3: mode <= wdata.
//  Reads (switchaddrcs && switchread, negedge): switchrdata <= register at addr,
//   zero-extended. Otherwise switchrdata holds its value.
//   - A simultaneous read and write at the same address returns the pre-write value.
//  IRQ: switchirq <= |(edge & ie), one clock after the flag or enable changes.
//   - Deasserts one clock after a W1C or IE clear.
//  Mode change: does not retroactively set flags. Only later stable changes are evaluated.
//  Reset mid-debounce: the pending transition is discarded.
//   - If switch_i is still high after reset release, it re-debounces.
//   - It then sets a rising edge flag, provided mode is 0.
//  Bits [15:WIDTH] of every register read as 0. Writes to those bits are ignored.
// TESTING  (WIDTH=16, DEBOUNCE_CYCLES=4)
//  1. switch_i 0x0000->0x0005 and held.
//     -> DATA reads 0x0005 from negedge 6 on; EDGE=0x0005; irq stays 0 (IE=0).
//  2. bit3 pulsed high 3 clocks then low.
//     -> DATA bit3 stays 0, EDGE bit3 stays 0, counter returns to 0.
//  3. IE=0x0001, bit0 rises -> irq=1 one clock after EDGE bit0 sets.
//     Write EDGE=0x0001 -> EDGE=0, irq=0 next clock.
//  4. MODE=0x0010, bit4 goes 1->0 -> EDGE=0x0010.
//     Bit4 going 0->1 alone leaves EDGE bit4 clear.
//  5. W1C of bit0 on the same edge stable bit0 rises -> EDGE bit0 remains 1 (set wins).
//  6. switrst asserted mid-debounce with switch_i=0xFFFF -> all outputs 0 immediately.
//     After release: DATA=0xFFFF after 6 clocks, EDGE=0xFFFF.

Source files
------------

// File: rtl/switch_port_dbnc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : switch_port_dbnc
// Description : Memory-mapped switch/button input port for the SoC bus.
//               Each input bit passes through a 2-flop synchroniser and a
//               counter debouncer. Debounced transitions set sticky W1C edge
//               flags; any flag with its enable bit set raises an interrupt.
//               Register map: 0 DATA (ro), 1 EDGE (w1c), 2 IE, 3 MODE.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_port_dbnc #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             switclk,
    input  logic             switrst,
    input  logic             switchaddrcs,
    input  logic             switchread,
    input  logic             switchwrite,
    input  logic [1:0]       switchaddr,
    input  logic [15:0]      switchwdata,
    output logic [15:0]      switchrdata,
    input  logic [WIDTH-1:0] switch_i,
    output logic             switchirq
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_EDGE = 2'd1;
    localparam logic [1:0] c_ADDR_IE   = 2'd2;
    localparam logic [1:0] c_ADDR_MODE = 2'd3;

    // Synchroniser and debounce state
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // CPU-visible registers
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_ie;
    logic [WIDTH-1:0] r_mode;

    // Combinational helpers
    logic [WIDTH-1:0] w_settle;    // bits whose debounced level flips this edge
    logic [WIDTH-1:0] w_edge_set;  // flags raised by a qualifying transition
    logic [WIDTH-1:0] w_edge_clr;  // flags cleared by a W1C write
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr;
    logic             w_rd;
    logic [15:0]      w_rdata_mux;

    assign w_wr    = switchaddrcs & switchwrite;
    assign w_rd    = switchaddrcs & switchread;
    assign w_wdata = switchwdata[WIDTH-1:0];

    // A bit settles when the synchronised level has differed from the
    // debounced level for DEBOUNCE_CYCLES consecutive clocks.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_settle
            assign w_settle[gi] = (r_sync2[gi] != r_stable[gi]) &&
                                  (r_cnt[gi] == c_CNT_LAST);
        end
    endgenerate

    // The new level is r_sync2; a mode bit of 0 flags rising, 1 flags falling.
    assign w_edge_set = w_settle & (r_sync2 ^ r_mode);
    assign w_edge_clr = (w_wr && (switchaddr == c_ADDR_EDGE)) ? w_wdata : '0;

    // Two-flop synchroniser for the raw asynchronous switch levels
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switch_i;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit persistence counters; any return to the old level restarts the count
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_LAST) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    // Debounced level flips exactly on the settling edge
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            r_stable <= '0;
        end else begin
            r_stable <= r_stable ^ w_settle;
        end
    end

    // Sticky edge flags; a new transition wins over a same-cycle W1C clear
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            r_edge <= '0;
        end else begin
            r_edge <= w_edge_set | (r_edge & ~w_edge_clr);
        end
    end

    // Interrupt-enable and edge-mode registers written from the bus
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            r_ie   <= '0;
            r_mode <= '0;
        end else if (w_wr) begin
            if (switchaddr == c_ADDR_IE) begin
                r_ie <= w_wdata;
            end
            if (switchaddr == c_ADDR_MODE) begin
                r_mode <= w_wdata;
            end
        end
    end

    // Read multiplexer; unused upper bits are zero
    always_comb begin
        w_rdata_mux = '0;
        case (switchaddr)
            c_ADDR_DATA: w_rdata_mux[WIDTH-1:0] = r_stable;
            c_ADDR_EDGE: w_rdata_mux[WIDTH-1:0] = r_edge;
            c_ADDR_IE:   w_rdata_mux[WIDTH-1:0] = r_ie;
            c_ADDR_MODE: w_rdata_mux[WIDTH-1:0] = r_mode;
            default:     w_rdata_mux = '0;
        endcase
    end

    // Registered read data captures pre-write register contents and holds otherwise
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            switchrdata <= '0;
        end else if (w_rd) begin
            switchrdata <= w_rdata_mux;
        end
    end

    // Interrupt follows enabled flags one clock later
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            switchirq <= 1'b0;
        end else begin
            switchirq <= |(r_edge & r_ie);
        end
    end

endmodule
`default_nettype wire
